// File: rtl/cpu_pkg.sv
// Shared definitions for the program sequencer: instruction field
// widths, opcode encodings and the sequencer state encoding.
package cpu_pkg;

    localparam int INSTR_W = 16;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 8;
    localparam int PC_W    = 8;
    localparam int CNT_W   = 10;

    localparam logic [OPC_W-1:0] OP_SET   = 4'h0;
    localparam logic [OPC_W-1:0] OP_INPUT = 4'h1;
    localparam logic [OPC_W-1:0] OP_COPY  = 4'h2;
    localparam logic [OPC_W-1:0] OP_MUL   = 4'h3;
    localparam logic [OPC_W-1:0] OP_ADD   = 4'h4;
    localparam logic [OPC_W-1:0] OP_NEG   = 4'h5;
    localparam logic [OPC_W-1:0] OP_AND   = 4'h6;
    localparam logic [OPC_W-1:0] OP_OR    = 4'h7;
    localparam logic [OPC_W-1:0] OP_SHL   = 4'h8;
    localparam logic [OPC_W-1:0] OP_GT    = 4'hB;
    localparam logic [OPC_W-1:0] OP_BRNZ  = 4'hC;
    localparam logic [OPC_W-1:0] OP_JMP   = 4'hD;
    localparam logic [OPC_W-1:0] OP_HALT  = 4'hE;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXECUTE,
        HALTED
    } seqState_t;

endpackage

// File: rtl/program_sequencer_if.sv
// Instruction memory bus. The sequencer (master) drives address and
// program select; the memory (slave) returns combinational data.
interface program_sequencer_if;
    import cpu_pkg::*;

    logic [PC_W-1:0]    imemAddress;
    logic [7:0]         imemProgramSelect;
    logic [INSTR_W-1:0] imemInstruction;

    modport master (
        output imemAddress,
        output imemProgramSelect,
        input  imemInstruction
    );

    modport slave (
        input  imemAddress,
        input  imemProgramSelect,
        output imemInstruction
    );

endinterface

// File: rtl/instruction_decoder.sv
// Combinational field extraction and control-class flags.
// In: instr. Out: opcode/rd/rs1/rs2/imm, isBranch/isJump/isHalt/isNop.
module instruction_decoder
    import cpu_pkg::*;
(
    input  logic [INSTR_W-1:0] instr,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rd,
    output logic [REG_W-1:0]   rs1,
    output logic [REG_W-1:0]   rs2,
    output logic [IMM_W-1:0]   imm,
    output logic               isBranch,
    output logic               isJump,
    output logic               isHalt,
    output logic               isNop
);

    assign opcode   = instr[15:12];
    assign rd       = instr[11:8];
    assign rs1      = instr[7:4];
    assign rs2      = instr[3:0];
    assign imm      = instr[7:0];

    assign isBranch = (opcode == OP_BRNZ);
    assign isJump   = (opcode == OP_JMP);
    assign isHalt   = (opcode == OP_HALT);

    // Anything not explicitly encoded is a NOP.
    assign isNop = !(opcode inside {
        OP_SET, OP_INPUT, OP_COPY, OP_MUL,
        OP_ADD, OP_NEG, OP_AND, OP_OR,
        OP_SHL, OP_GT, OP_BRNZ, OP_JMP,
        OP_HALT
    });

endmodule

// File: rtl/program_sequencer.sv
// Fetch/decode/execute sequencer: owns PC, drives instruction memory,
// strobes execValid once per instruction, resolves branches and HALT.
// Ports: clk, rst_n, start, programSelectIn, imem (master bus),
// rs1Addr/rs2Addr/rs1Data, exec* strobe bundle, busy/halted/fault,
// pc, instrCount.
module program_sequencer
    import cpu_pkg::*;
#(
    parameter int IMEM_DEPTH = 128,
    parameter int MAX_INSTR  = 1023
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [7:0]          programSelectIn,
    program_sequencer_if.master imem,
    output logic [REG_W-1:0]    rs1Addr,
    output logic [REG_W-1:0]    rs2Addr,
    input  logic [7:0]          rs1Data,
    output logic                execValid,
    output logic [OPC_W-1:0]    execOpcode,
    output logic [REG_W-1:0]    execRd,
    output logic [REG_W-1:0]    execRs1,
    output logic [REG_W-1:0]    execRs2,
    output logic [IMM_W-1:0]    execImm,
    output logic                busy,
    output logic                halted,
    output logic                fault,
    output logic [PC_W-1:0]     pc,
    output logic [CNT_W-1:0]    instrCount
);

    localparam logic [9:0] DEPTH10 = 10'(IMEM_DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_INSTR - 1);

    seqState_t          state;
    logic [PC_W-1:0]    pcReg;
    logic [INSTR_W-1:0] ir;
    logic [7:0]         progSel;
    logic [CNT_W-1:0]   count;
    logic               faultReg;

    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0] imm;
    logic isBranch, isJump, isHalt, isNop;

    instruction_decoder u_dec (
        .instr    (ir),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .imm      (imm),
        .isBranch (isBranch),
        .isJump   (isJump),
        .isHalt   (isHalt),
        .isNop    (isNop)
    );

    // 10-bit signed target: bit 9 set means the result went negative.
    logic [9:0] pcNext1;
    logic [9:0] target;
    logic       targetBad;
    logic       lastCount;

    always_comb begin
        pcNext1 = {2'b00, pcReg} + 10'd1;
        target  = pcNext1;
        unique case (1'b1)
            isBranch: begin
                if (rs1Data != 8'd0)
                    target = pcNext1 + {6'd0, rs2};
            end
            isJump:  target = pcNext1 + {{2{imm[7]}}, imm};
            isHalt:  target = {2'b00, pcReg};
            isNop:   target = pcNext1;
            default: target = pcNext1;
        endcase
    end

    assign targetBad = target[9] || (target >= DEPTH10);
    assign lastCount = (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            pcReg    <= '0;
            ir       <= '0;
            progSel  <= '0;
            count    <= '0;
            faultReg <= 1'b0;
        end else begin
            unique case (state)
                IDLE, HALTED: begin
                    if (start) begin
                        state    <= FETCH;
                        pcReg    <= '0;
                        count    <= '0;
                        faultReg <= 1'b0;
                        progSel  <= programSelectIn;
                    end
                end
                FETCH: begin
                    ir    <= imem.imemInstruction;
                    state <= DECODE;
                end
                DECODE: state <= EXECUTE;
                EXECUTE: begin
                    count <= count + 1'b1;
                    if (isHalt) begin
                        state <= HALTED;
                    end else if (targetBad || lastCount) begin
                        // PC stays on the faulting instruction.
                        state    <= HALTED;
                        faultReg <= 1'b1;
                    end else begin
                        state <= FETCH;
                        pcReg <= target[PC_W-1:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign imem.imemAddress       = pcReg;
    assign imem.imemProgramSelect = progSel;

    assign rs1Addr    = rs1;
    assign rs2Addr    = rs2;
    assign execValid  = (state == EXECUTE);
    assign execOpcode = opcode;
    assign execRd     = rd;
    assign execRs1    = rs1;
    assign execRs2    = rs2;
    assign execImm    = imm;

    assign busy = (state == FETCH) || (state == DECODE) ||
                  (state == EXECUTE);
    assign halted     = (state == HALTED);
    assign fault      = faultReg;
    assign pc         = pcReg;
    assign instrCount = count;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expected execute strobes
// are queued per scenario and compared against observed strobes.
module tb_program_sequencer;

    typedef struct {
        int         cyc;
        logic [7:0] pc;
        logic [3:0] op;
    } ev_t;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] addr;
        logic [7:0] sel;
        logic       halted;
        logic       busy;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  programSelectIn;
    logic [3:0]  rs1Addr, rs2Addr;
    logic [7:0]  rs1Data;
    logic        execValid;
    logic [3:0]  execOpcode, execRd, execRs1, execRs2;
    logic [7:0]  execImm;
    logic        busy, halted, fault;
    logic [7:0]  pc;
    logic [9:0]  instrCount;

    logic [15:0] mem [0:255];
    logic [7:0]  regs [0:15];

    ev_t expQ[$];
    ev_t obsQ[$];
    int  nCmp = 0;
    int  nErr = 0;

    program_sequencer_if imem();

    program_sequencer #(
        .IMEM_DEPTH (128),
        .MAX_INSTR  (1023)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .programSelectIn (programSelectIn),
        .imem            (imem),
        .rs1Addr         (rs1Addr),
        .rs2Addr         (rs2Addr),
        .rs1Data         (rs1Data),
        .execValid       (execValid),
        .execOpcode      (execOpcode),
        .execRd          (execRd),
        .execRs1         (execRs1),
        .execRs2         (execRs2),
        .execImm         (execImm),
        .busy            (busy),
        .halted          (halted),
        .fault           (fault),
        .pc              (pc),
        .instrCount      (instrCount)
    );

    always #5 clk = ~clk;

    assign imem.imemInstruction = mem[imem.imemAddress];
    assign rs1Data = regs[rs1Addr];

    // Tiny datapath model: only SET and COPY write registers.
    always @(posedge clk) begin
        if (execValid) begin
            if (execOpcode == 4'h0) regs[execRd] <= execImm;
            if (execOpcode == 4'h2) regs[execRd] <= regs[execRs1];
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 16'hE000;
    endtask

    task automatic load_straight();
        clear_mem();
        mem[0] = 16'h0102;
        mem[1] = 16'h2F10;
        mem[2] = 16'hE000;
    endtask

    // Starts a run and logs every strobe; cycle 1 is the one after
    // the edge that samples start.
    task automatic run_prog(input logic [7:0] sel, input int budget,
                            input bit poke, output int haltCyc,
                            output snap_t s1);
        obsQ.delete();
        s1 = '{8'hxx, 8'hxx, 8'hxx, 1'bx, 1'bx};
        @(negedge clk);
        programSelectIn = sel;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        haltCyc = -1;
        for (int c = 1; c <= budget; c++) begin
            if (c == 1) begin
                s1.pc = pc;
                s1.addr = imem.imemAddress;
                s1.sel = imem.imemProgramSelect;
                s1.halted = halted;
                s1.busy = busy;
            end
            if (poke) begin
                start = (c == 4) || (c == 5);
                if (c == 4) programSelectIn = 8'hFF;
            end
            if (execValid) obsQ.push_back('{c, pc, execOpcode});
            if (halted) begin
                haltCyc = c;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        programSelectIn = 8'h00;
        repeat (2) @(negedge clk);
        nCmp++;
        if ({pc, imem.imemAddress, imem.imemProgramSelect} !== 24'd0) begin
            nErr++;
            $display("FAIL rst_addr got pc=%h a=%h s=%h want 0",
                     pc, imem.imemAddress, imem.imemProgramSelect);
        end
        nCmp++;
        if ({execValid, busy, halted, fault} !== 4'b0000) begin
            nErr++;
            $display("FAIL rst_flags got %b want 0000",
                     {execValid, busy, halted, fault});
        end
        nCmp++;
        if (instrCount !== 10'd0) begin
            nErr++;
            $display("FAIL rst_count got %0d want 0", instrCount);
        end
        nCmp++;
        if ({execOpcode, execRd, execRs1, execRs2, execImm,
             rs1Addr, rs2Addr} !== 32'd0) begin
            nErr++;
            $display("FAIL rst_fields got nonzero want 0");
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_straight_line();
        int haltCyc;
        snap_t s1;
        ev_t e, o;
        load_straight();
        expQ.push_back('{3, 8'd0, 4'h0});
        expQ.push_back('{6, 8'd1, 4'h2});
        expQ.push_back('{9, 8'd2, 4'hE});
        run_prog(8'h5A, 100, 1'b0, haltCyc, s1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nCmp++;
            if (obsQ.size() == 0) begin
                nErr++;
                $display("FAIL sl_strobe got none want pc=%0d", e.pc);
            end else begin
                o = obsQ.pop_front();
                if (o.cyc !== e.cyc || o.pc !== e.pc || o.op !== e.op) begin
                    nErr++;
                    $display("FAIL sl_strobe got c%0d pc%0d op%h want c%0d pc%0d op%h",
                             o.cyc, o.pc, o.op, e.cyc, e.pc, e.op);
                end
            end
        end
        nCmp++;
        if (obsQ.size() != 0) begin
            nErr++;
            $display("FAIL sl_extra got %0d want 0", obsQ.size());
        end
        nCmp++;
        if (s1.addr !== 8'd0 || s1.busy !== 1'b1) begin
            nErr++;
            $display("FAIL sl_cyc1 got a=%h b=%b want 0/1", s1.addr, s1.busy);
        end
        nCmp++;
        if (haltCyc != 10) begin
            nErr++;
            $display("FAIL sl_halt_cyc got %0d want 10", haltCyc);
        end
        nCmp++;
        if ({pc, instrCount, fault, busy} !== {8'd2, 10'd3, 1'b0, 1'b0}) begin
            nErr++;
            $display("FAIL sl_final got pc=%0d n=%0d f=%b b=%b want 2/3/0/0",
                     pc, instrCount, fault, busy);
        end
        nCmp++;
        if (regs[15] !== 8'd2) begin
            nErr++;
            $display("FAIL sl_r15 got %0d want 2", regs[15]);
        end
    endtask

    task automatic test_branch();
        int haltCyc;
        snap_t s1;
        ev_t e, o;
        for (int v = 1; v >= 0; v--) begin
            clear_mem();
            mem[0] = 16'h0500 | 16'(v);
            for (int k = 1; k <= 5; k++) mem[k] = 16'h9000;
            mem[6] = 16'hC051;
            for (int k = 0; k <= 6; k++)
                expQ.push_back('{3 + 3 * k, 8'(k),
                                 (k == 0) ? 4'h0 : (k == 6) ? 4'hC : 4'h9});
            expQ.push_back('{24, (v != 0) ? 8'd8 : 8'd7, 4'hE});
            run_prog(8'h01, 100, 1'b0, haltCyc, s1);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                nCmp++;
                if (obsQ.size() == 0) begin
                    nErr++;
                    $display("FAIL br%0d_strobe got none want pc=%0d", v, e.pc);
                end else begin
                    o = obsQ.pop_front();
                    if (o.cyc !== e.cyc || o.pc !== e.pc || o.op !== e.op) begin
                        nErr++;
                        $display("FAIL br%0d_strobe got c%0d pc%0d want c%0d pc%0d",
                                 v, o.cyc, o.pc, e.cyc, e.pc);
                    end
                end
            end
            nCmp++;
            if (pc !== ((v != 0) ? 8'd8 : 8'd7) || fault !== 1'b0 ||
                haltCyc != 25) begin
                nErr++;
                $display("FAIL br%0d_final got pc=%0d f=%b hc=%0d want %0d/0/25",
                         v, pc, fault, haltCyc, (v != 0) ? 8 : 7);
            end
        end
    endtask

    task automatic test_jump();
        int haltCyc;
        snap_t s1;
        ev_t e, o;
        for (int part = 0; part < 2; part++) begin
            clear_mem();
            if (part == 0) begin
                mem[0] = 16'hD009;
                mem[10] = 16'h9000;
                mem[11] = 16'h9000;
                mem[12] = 16'hD0F6;
                mem[3] = 16'hE000;
                expQ.push_back('{3, 8'd0, 4'hD});
                expQ.push_back('{6, 8'd10, 4'h9});
                expQ.push_back('{9, 8'd11, 4'h9});
                expQ.push_back('{12, 8'd12, 4'hD});
                expQ.push_back('{15, 8'd3, 4'hE});
            end else begin
                for (int k = 0; k < 5; k++) begin
                    mem[k] = 16'h9000;
                    expQ.push_back('{3 + 3 * k, 8'(k), 4'h9});
                end
                mem[5] = 16'hD0F0;
                expQ.push_back('{18, 8'd5, 4'hD});
            end
            run_prog(8'h04, 100, 1'b0, haltCyc, s1);
            while (expQ.size() > 0) begin
                e = expQ.pop_front();
                nCmp++;
                if (obsQ.size() == 0) begin
                    nErr++;
                    $display("FAIL jmp%0d_strobe got none want pc=%0d", part, e.pc);
                end else begin
                    o = obsQ.pop_front();
                    if (o.cyc !== e.cyc || o.pc !== e.pc || o.op !== e.op) begin
                        nErr++;
                        $display("FAIL jmp%0d_strobe got c%0d pc%0d want c%0d pc%0d",
                                 part, o.cyc, o.pc, e.cyc, e.pc);
                    end
                end
            end
            nCmp++;
            if (part == 0 && {pc, fault, halted, instrCount} !==
                             {8'd3, 1'b0, 1'b1, 10'd5}) begin
                nErr++;
                $display("FAIL jmp_back got pc=%0d f=%b h=%b n=%0d want 3/0/1/5",
                         pc, fault, halted, instrCount);
            end
            if (part == 1 && {pc, fault, halted, instrCount} !==
                             {8'd5, 1'b1, 1'b1, 10'd6}) begin
                nErr++;
                $display("FAIL jmp_neg got pc=%0d f=%b h=%b n=%0d want 5/1/1/6",
                         pc, fault, halted, instrCount);
            end
        end
    endtask

    task automatic test_out_of_range();
        int haltCyc;
        snap_t s1;
        ev_t e, o;
        clear_mem();
        mem[0] = 16'hD063;
        mem[100] = 16'hD07F;
        expQ.push_back('{3, 8'd0, 4'hD});
        expQ.push_back('{6, 8'd100, 4'hD});
        run_prog(8'h08, 100, 1'b0, haltCyc, s1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nCmp++;
            if (obsQ.size() == 0) begin
                nErr++;
                $display("FAIL oor_strobe got none want pc=%0d", e.pc);
            end else begin
                o = obsQ.pop_front();
                if (o.cyc !== e.cyc || o.pc !== e.pc) begin
                    nErr++;
                    $display("FAIL oor_strobe got c%0d pc%0d want c%0d pc%0d",
                             o.cyc, o.pc, e.cyc, e.pc);
                end
            end
        end
        nCmp++;
        if ({pc, fault, halted} !== {8'd100, 1'b1, 1'b1} || haltCyc != 7) begin
            nErr++;
            $display("FAIL oor_final got pc=%0d f=%b h=%b hc=%0d want 100/1/1/7",
                     pc, fault, halted, haltCyc);
        end
    endtask

    task automatic test_start_handling();
        int haltCyc;
        snap_t s1;
        ev_t e, o;
        load_straight();
        expQ.push_back('{3, 8'd0, 4'h0});
        expQ.push_back('{6, 8'd1, 4'h2});
        expQ.push_back('{9, 8'd2, 4'hE});
        run_prog(8'h5A, 100, 1'b1, haltCyc, s1);
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nCmp++;
            if (obsQ.size() == 0) begin
                nErr++;
                $display("FAIL busy_strobe got none want pc=%0d", e.pc);
            end else begin
                o = obsQ.pop_front();
                if (o.cyc !== e.cyc || o.pc !== e.pc) begin
                    nErr++;
                    $display("FAIL busy_strobe got c%0d pc%0d want c%0d pc%0d",
                             o.cyc, o.pc, e.cyc, e.pc);
                end
            end
        end
        nCmp++;
        if (imem.imemProgramSelect !== 8'h5A || haltCyc != 10) begin
            nErr++;
            $display("FAIL busy_sel got s=%h hc=%0d want 5a/10",
                     imem.imemProgramSelect, haltCyc);
        end
        run_prog(8'h02, 100, 1'b0, haltCyc, s1);
        nCmp++;
        if ({s1.sel, s1.pc, s1.addr, s1.halted, s1.busy} !==
            {8'h02, 8'd0, 8'd0, 1'b0, 1'b1}) begin
            nErr++;
            $display("FAIL restart got s=%h pc=%0d a=%0d h=%b b=%b want 02/0/0/0/1",
                     s1.sel, s1.pc, s1.addr, s1.halted, s1.busy);
        end
        nCmp++;
        if (haltCyc != 10 || instrCount !== 10'd3) begin
            nErr++;
            $display("FAIL restart_run got hc=%0d n=%0d want 10/3",
                     haltCyc, instrCount);
        end
    endtask

    task automatic test_watchdog();
        int haltCyc;
        snap_t s1;
        clear_mem();
        mem[0] = 16'hD0FF;
        run_prog(8'h10, 4000, 1'b0, haltCyc, s1);
        nCmp++;
        if (haltCyc != 3070 || obsQ.size() != 1023) begin
            nErr++;
            $display("FAIL wdog_time got hc=%0d strobes=%0d want 3070/1023",
                     haltCyc, obsQ.size());
        end
        nCmp++;
        if ({instrCount, fault, halted, pc} !==
            {10'd1023, 1'b1, 1'b1, 8'd0}) begin
            nErr++;
            $display("FAIL wdog_final got n=%0d f=%b h=%b pc=%0d want 1023/1/1/0",
                     instrCount, fault, halted, pc);
        end
    endtask

    task automatic test_reset_mid();
        int strobes = 0;
        load_straight();
        @(negedge clk);
        programSelectIn = 8'h33;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        nCmp++;
        if ({pc, imem.imemAddress, imem.imemProgramSelect, instrCount,
             execValid, busy, halted, fault} !== 38'd0) begin
            nErr++;
            $display("FAIL midrst got pc=%0d a=%0d s=%h n=%0d v%b b%b h%b f%b want 0",
                     pc, imem.imemAddress, imem.imemProgramSelect,
                     instrCount, execValid, busy, halted, fault);
        end
        nCmp++;
        if ({execOpcode, execRd, execRs1, execRs2, execImm,
             rs1Addr, rs2Addr} !== 32'd0) begin
            nErr++;
            $display("FAIL midrst_fields got nonzero want 0");
        end
        if (execValid) strobes++;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            if (execValid) strobes++;
            @(negedge clk);
        end
        nCmp++;
        if (strobes != 0 || busy !== 1'b0) begin
            nErr++;
            $display("FAIL midrst_idle got strobes=%0d b=%b want 0/0",
                     strobes, busy);
        end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_branch();
        test_jump();
        test_out_of_range();
        test_start_handling();
        test_watchdog();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction fetch/control unit that reads the instruction memory: it owns the program counter, drives the memory's address and program-select inputs, latches and decodes each 16-bit instruction, resolves branches, jumps and HALT, and issues one decoded execute strobe per instruction to the register file/ALU datapath. It sits between the board-level start/select controls and the datapath, and is the only master of the instruction memory.

## Interface
Parameters:
- IMEM_DEPTH, 128: valid instruction addresses are 0..IMEM_DEPTH-1.
- MAX_INSTR, 1023: executed-instruction budget per run before a watchdog fault.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- start  in  1  begin a run at PC 0; honoured only in IDLE or HALTED.
- programSelectIn  in  8  one-hot-ish program switches, captured on an accepted start.
- imemAddress  out  8  instruction memory address (= PC).
- imemProgramSelect  out  8  captured program select.
- imemInstruction  in  16  combinational instruction memory data.
- rs1Addr, rs2Addr  out  4 each  register file read addresses, valid in DECODE and EXECUTE.
- rs1Data  in  8  register file read data for rs1Addr (combinational).
- execValid  out  1  one-cycle strobe: exec fields valid, datapath performs the instruction.
- execOpcode  out  4; execRd, execRs1, execRs2  out  4 each; execImm  out  8.
- busy  out  1  high in FETCH, DECODE and EXECUTE.
- halted  out  1  run ended (HALT or fault).
- fault  out  1  run ended abnormally.
- pc  out  8  current program counter.
- instrCount  out  10  instructions executed in the current run.

## Operation
- Fields: opcode [15:12], rd [11:8], rs1 [7:4], rs2 [3:0], imm [7:0].
- Opcodes: 0000 SET, 0001 INPUT, 0010 COPY, 0011 MUL, 0100 ADD, 0101 NEG, 0110 AND, 0111 OR, 1000 SHL, 1011 GT: all pass to the datapath, PC+1.
- 1100 BRNZ: condition register rs1, offset rs2 (unsigned 4-bit). Taken if rs1Data != 0; then target = PC+1+offset, else PC+1.
- 1101 JMP: target = PC+1+sext(imm).
- 1110 HALT.
- 1001, 1010, 1111: NOP, PC+1.
- BRNZ, JMP, HALT and NOP still strobe execValid. The datapath ignores them.
- Target arithmetic is done as 10-bit signed. A result <0 or ≥IMEM_DEPTH sets fault and goes to HALTED; there is no wrap-around.
- States:
  - IDLE: start → FETCH, with PC=0, instrCount=0, select captured.
  - FETCH: instruction register ← imemInstruction → DECODE.
  - DECODE: drive rs1/rs2 → EXECUTE.
  - EXECUTE: execValid=1, instrCount+1, PC ← next. HALT → HALTED; target fault → HALTED with fault; instrCount reaching MAX_INSTR on a non-HALT instruction → HALTED with fault; otherwise → FETCH.
  - HALTED: start → FETCH, clearing halted, fault, PC and instrCount.
- start while busy is ignored; programSelectIn changes while busy are ignored.
- When halted, the PC holds the HALT address, or the faulting instruction address on a fault.

## Timing
- Reset, sampled synchronously on any edge and in any state (including mid-instruction): state IDLE, pc=0, imemAddress=0, imemProgramSelect=0, execValid=0, exec fields 0, rs1Addr/rs2Addr 0, busy=0, halted=0, fault=0, instrCount=0.
- Latency: start sampled at edge 0 → FETCH in cycle 1 with imemAddress=0 → DECODE cycle 2 → execValid high in cycle 3 → next FETCH in cycle 4.
- Throughput is exactly 3 cycles per instruction; there are no stalls.
- imemAddress changes only on the EXECUTE→FETCH edge. Memory data is sampled at the end of FETCH.
- The datapath writes on the edge ending EXECUTE. A BRNZ's rs1Data therefore reflects all prior instructions.
- halted and fault rise on the edge after the final EXECUTE; busy falls on the same edge.

## Structure
- Package cpu_pkg holds:
  - opcode constants (OP_SET … OP_HALT);
  - field-slice widths;
  - the sequencer state enum (IDLE, FETCH, DECODE, EXECUTE, HALTED).
- Sub-module instruction_decoder: combinational field extraction plus isBranch/isJump/isHalt/isNop classification from the instruction register.
- The sequencer FSM, PC, target arithmetic and counters live in program_sequencer.

## Test plan
- Straight line: memory SET R1,2 / COPY R15,R1 / HALT with start pulse → three execValid strobes at cycles 3, 6, 9; halted=1 at cycle 10, pc=2, instrCount=3, fault=0.
- BRNZ taken vs not: at PC 6, 0xC051 with rs1Data=1 → next imemAddress 8; with rs1Data=0 → 7.
- Backward JMP: 0xD0F6 at PC 12 → next imemAddress 3; 0xD0F0 at PC 5 (target −10) → fault=1, halted=1, pc=5.
- Out-of-range: JMP +127 from PC 100 → fault. An infinite loop of 0xD0FF → fault once instrCount=1023.
- Start handling: start while busy ignored (PC sequence unchanged). Start in HALTED with programSelectIn=0x02 → imemProgramSelect=0x02, pc=0, halted=0.
- Reset mid-run: rst_n low during DECODE → all outputs at reset values next cycle; no execValid for the interrupted instruction.
